ila_grant_sequencer: RTL and testbench
======================================

# ila_grant_sequencer

Execution controller on the grant side of an ILA-generated instruction model. It samples the model's per-instruction decode vector, valid flag and pc. It drives back the one-hot grant vector that lets exactly one decoded instruction commit per cycle. Run, single-step, stop, an instruction budget and decode-integrity checking are provided so a test harness or debug host can pace the model.

## Interface
Parameters:
- NUM_INSTR, 3, width of decode/grant vectors (bit 0 Load, 1 Add, 2 Store)
- PC_W, 8, pc width
- CNT_W, 16, width of budget and retired counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ila_valid  in  1  model valid flag
- ila_decode  in  NUM_INSTR  accumulated decode vector from model
- ila_pc  in  PC_W  current model pc
- ila_grant  out  NUM_INSTR  grant vector to model (Mealy: registered state AND current decode)
- cmd_run  in  1  pulse: enter free-run
- cmd_step  in  1  pulse: commit exactly one instruction
- cmd_stop  in  1  pulse: stop / clear error
- budget  in  CNT_W  instructions per run, sampled on cmd_run; 0 = unbounded
- busy  out  1  state is RUN or STEP
- done  out  1  one-cycle pulse on run/step completion
- err  out  1  sticky decode-integrity error
- retired  out  CNT_W  instructions granted since last cmd_run/cmd_step, saturating
- last_pc  out  PC_W  pc of most recently granted instruction

## Operation
- States: IDLE, RUN, STEP, HALT. Reset: IDLE. Reset values: ila_grant 0, busy 0, done 0, err 0, retired 0, last_pc 0, budget register 0.
- Command priority in the same cycle: stop > step > run.
- IDLE: cmd_run -> RUN, latch budget, retired <= 0. cmd_step -> STEP, retired <= 0. cmd_stop has no effect.
- Fire condition: state is RUN/STEP, ila_valid=1, ila_decode one-hot, no cmd_stop this cycle. When fire=1, ila_grant = ila_decode; otherwise ila_grant = 0.
- On a fire edge: retired <= retired+1, saturating at all-ones; last_pc <= ila_pc.
- RUN exit on fire:
  - budget≠0 and retired+1 == budget -> IDLE, done pulse next cycle.
  - Otherwise stay in RUN.
- STEP: first fire -> IDLE, done pulse. No fire -> wait in STEP indefinitely.
- ila_valid=0 in RUN/STEP: no grant, hold state. This is not an error.
- Integrity: in RUN/STEP with ila_valid=1 and ila_decode zero or multi-hot:
  - grant 0.
  - -> HALT, err <= 1.
  - No done pulse.
- HALT: busy 0, all run/step commands ignored. cmd_stop -> IDLE, err <= 0.
- cmd_stop in RUN/STEP: grant suppressed that cycle, -> IDLE, no done pulse, retired keeps its value.
- Reset mid-operation: next cycle is IDLE with all reset values; a grant asserted in the reset cycle is permitted to be combinationally nonzero only if state was RUN/STEP. The model ignores commits during rst.

## Timing
- Grant is same-cycle: the decode presented in cycle t is granted in cycle t and commits at edge t→t+1.
- Command-to-first-grant latency: 1 cycle (command edge moves state).
- done, state, retired and last_pc update on the edge ending the fire cycle. done is high exactly one cycle.
- Budget = N yields exactly N grants in N cycles when the decode is continuously valid.

## Configuration
- ILA_GRANT_SEQ_BKPT_EN defined:
  - Adds ports bkpt_en (in, 1), bkpt_pc (in, PC_W) and bkpt_hit (out, 1 pulse).
  - In RUN with bkpt_en=1 and ila_pc==bkpt_pc: grant suppressed, -> IDLE, bkpt_hit pulse, no done. The breakpoint instruction is not executed.
  - STEP ignores breakpoints, so single-stepping off a breakpoint works.
- Not defined: ports absent; no breakpoint logic.

## Structure
- Package ila_seq_pkg:
  - State enum (IDLE, RUN, STEP, HALT).
  - Instruction index constants (INSTR_LOAD=0, INSTR_ADD=1, INSTR_STORE=2).
  - Default widths.
- Sub-module ila_onehot_chk: combinational check returning is_onehot for NUM_INSTR bits. All other logic is in the top.

## Test plan
- Reset, then cmd_run with budget=4 and decode=3'b001 valid every cycle -> grants 001 for exactly 4 cycles, retired=4, done pulses once, state IDLE.
- cmd_step with decode=3'b010 and valid low for 3 cycles, then high -> no grant for 3 cycles, one grant, done, retired=1, last_pc = pc of that cycle.
- RUN with budget=0, decode 3'b110 injected -> grant 0, err=1, HALT. cmd_run ignored. cmd_stop -> IDLE, err=0.
- RUN unbounded, cmd_stop and cmd_step asserted together -> grant 0 that cycle, IDLE, no done.
- retired preset near saturation with CNT_W=4, budget=0, 20 grants -> retired holds 15.
- BKPT_EN: bkpt_pc=8'h05, RUN from pc 0, one instruction per cycle -> grants at pc 0–4, bkpt_hit when pc=5. cmd_step then grants pc 5.

Source files
------------

// File: rtl/ila_seq_pkg.sv
// Shared types and constants for the ILA grant sequencer.
package ila_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } seq_state_e;

    localparam int unsigned INSTR_LOAD  = 0;
    localparam int unsigned INSTR_ADD   = 1;
    localparam int unsigned INSTR_STORE = 2;

    localparam int unsigned DEF_NUM_INSTR = 3;
    localparam int unsigned DEF_PC_W      = 8;
    localparam int unsigned DEF_CNT_W     = 16;

endpackage

// File: rtl/ila_onehot_chk.sv
// Combinational one-hot detector for the decode vector.
module ila_onehot_chk #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] vec,
    output logic         is_onehot
);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    always_comb begin
        is_onehot = (vec != '0) && ((vec & (vec - N'(1))) == '0);
    end

endmodule

// File: rtl/ila_grant_sequencer.sv
// Grant-side execution controller for an ILA instruction model: run/step/stop pacing,
// instruction budget and decode-integrity halt. Optional breakpoint: ILA_GRANT_SEQ_BKPT_EN.
module ila_grant_sequencer
    import ila_seq_pkg::*;
#(
    parameter int unsigned NUM_INSTR = DEF_NUM_INSTR,
    parameter int unsigned PC_W      = DEF_PC_W,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ila_valid,
    input  logic [NUM_INSTR-1:0] ila_decode,
    input  logic [PC_W-1:0]      ila_pc,
    output logic [NUM_INSTR-1:0] ila_grant,
    input  logic                 cmd_run,
    input  logic                 cmd_step,
    input  logic                 cmd_stop,
    input  logic [CNT_W-1:0]     budget,
`ifdef ILA_GRANT_SEQ_BKPT_EN
    input  logic                 bkpt_en,
    input  logic [PC_W-1:0]      bkpt_pc,
    output logic                 bkpt_hit,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     retired,
    output logic [PC_W-1:0]      last_pc
);

    localparam int unsigned     CNT_W1  = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_e       state, state_d;
    logic [CNT_W-1:0] budget_q, budget_d;
    logic [CNT_W-1:0] retired_d;
    logic [PC_W-1:0]  last_pc_d;
    logic             done_d, err_d;
    logic             is_onehot, active, bkpt_stop, fire, bad, budget_hit;
    logic [CNT_W:0]   retired_inc;
`ifdef ILA_GRANT_SEQ_BKPT_EN
    logic             bkpt_hit_d;
`endif

    ila_onehot_chk #(.N(NUM_INSTR)) u_onehot (
        .vec       (ila_decode),
        .is_onehot (is_onehot)
    );

    assign active = (state == RUN) || (state == STEP);
    assign busy   = active;

`ifdef ILA_GRANT_SEQ_BKPT_EN
    // Breakpoints only stop free-run so a step can move off the breakpoint pc.
    assign bkpt_stop = (state == RUN) && bkpt_en && (ila_pc == bkpt_pc);
`else
    assign bkpt_stop = 1'b0;
`endif

    assign fire = active && ila_valid && is_onehot  && !cmd_stop && !bkpt_stop;
    assign bad  = active && ila_valid && !is_onehot && !cmd_stop && !bkpt_stop;

    // Mealy grant: commit lands on the edge closing this cycle.
    assign ila_grant = fire ? ila_decode : '0;

    assign retired_inc = {1'b0, retired} + CNT_W1'(1);
    assign budget_hit  = (budget_q != '0) && (retired_inc == {1'b0, budget_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            budget_q <= '0;
            retired  <= '0;
            last_pc  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef ILA_GRANT_SEQ_BKPT_EN
            bkpt_hit <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            budget_q <= budget_d;
            retired  <= retired_d;
            last_pc  <= last_pc_d;
            done     <= done_d;
            err      <= err_d;
`ifdef ILA_GRANT_SEQ_BKPT_EN
            bkpt_hit <= bkpt_hit_d;
`endif
        end
    end

    // Next-state and registered-output logic; stop outranks step outranks run.
    always_comb begin
        state_d   = state;
        budget_d  = budget_q;
        retired_d = retired;
        last_pc_d = last_pc;
        done_d    = 1'b0;
        err_d     = err;
`ifdef ILA_GRANT_SEQ_BKPT_EN
        bkpt_hit_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_step) begin
                    state_d   = STEP;
                    retired_d = '0;
                end else if (cmd_run) begin
                    state_d   = RUN;
                    budget_d  = budget;
                    retired_d = '0;
                end
            end
            RUN, STEP: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (bkpt_stop) begin
                    state_d = IDLE;
`ifdef ILA_GRANT_SEQ_BKPT_EN
                    bkpt_hit_d = 1'b1;
`endif
                end else if (bad) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end else if (fire) begin
                    retired_d = (retired == CNT_MAX) ? retired : retired_inc[CNT_W-1:0];
                    last_pc_d = ila_pc;
                    if ((state == STEP) || budget_hit) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            HALT: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ila_grant_sequencer.sv
// Self-checking bench for ila_grant_sequencer with a cycle-level reference model.
module tb_ila_grant_sequencer;

    localparam int unsigned NI   = 3;
    localparam int unsigned PW   = 8;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, ila_valid, cmd_run, cmd_step, cmd_stop;
    logic [NI-1:0] ila_decode;
    logic [PW-1:0] ila_pc;
    logic [CW-1:0] budget;
    logic [NI-1:0] ila_grant;
    logic          busy, done, err;
    logic [CW-1:0] retired;
    logic [PW-1:0] last_pc;
`ifdef ILA_GRANT_SEQ_BKPT_EN
    logic          bkpt_en;
    logic [PW-1:0] bkpt_pc;
    logic          bkpt_hit;
    bit            m_bkpt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 run, 2 step, 3 halted
    int m_mode, m_budget, m_retired, m_last_pc;
    bit m_err, m_done;

    always #5 clk = ~clk;

    ila_grant_sequencer #(.NUM_INSTR(NI), .PC_W(PW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ila_valid  (ila_valid),
        .ila_decode (ila_decode),
        .ila_pc     (ila_pc),
        .ila_grant  (ila_grant),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_stop   (cmd_stop),
        .budget     (budget),
`ifdef ILA_GRANT_SEQ_BKPT_EN
        .bkpt_en    (bkpt_en),
        .bkpt_pc    (bkpt_pc),
        .bkpt_hit   (bkpt_hit),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err),
        .retired    (retired),
        .last_pc    (last_pc)
    );

    function automatic bit bkpt_block();
`ifdef ILA_GRANT_SEQ_BKPT_EN
        return (m_mode == 1) && bkpt_en && (ila_pc == bkpt_pc);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [NI-1:0] exp_grant();
        if ((m_mode == 1 || m_mode == 2) && ila_valid && $countones(ila_decode) == 1
            && !cmd_stop && !bkpt_block())
            return ila_decode;
        return '0;
    endfunction

    task automatic model_update();
        int old;
        m_done = 1'b0;
`ifdef ILA_GRANT_SEQ_BKPT_EN
        m_bkpt = 1'b0;
`endif
        if (rst) begin
            m_mode = 0; m_budget = 0; m_retired = 0; m_last_pc = 0; m_err = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (cmd_step) begin
                        m_mode = 2; m_retired = 0;
                    end else if (cmd_run) begin
                        m_mode = 1; m_budget = int'(budget); m_retired = 0;
                    end
                end
                1, 2: begin
                    if (cmd_stop) begin
                        m_mode = 0;
                    end else if (bkpt_block()) begin
                        m_mode = 0;
`ifdef ILA_GRANT_SEQ_BKPT_EN
                        m_bkpt = 1'b1;
`endif
                    end else if (ila_valid) begin
                        if ($countones(ila_decode) != 1) begin
                            m_mode = 3; m_err = 1'b1;
                        end else begin
                            old       = m_retired;
                            m_retired = (old + 1 > CMAX) ? CMAX : old + 1;
                            m_last_pc = int'(ila_pc);
                            if (m_mode == 2 || (m_budget != 0 && old + 1 == m_budget)) begin
                                m_mode = 0; m_done = 1'b1;
                            end
                        end
                    end
                end
                3: if (cmd_stop) begin m_mode = 0; m_err = 1'b0; end
                default: m_mode = 0;
            endcase
        end
    endtask

    // Advance one clock; command pulses last exactly one cycle.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ila_valid = 1'b0; ila_decode = '0; ila_pc = '0; budget = '0;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
`ifdef ILA_GRANT_SEQ_BKPT_EN
        bkpt_en = 1'b0; bkpt_pc = '0;
`endif
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ila_grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b want 000", ila_grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
        checks++; if (last_pc !== 8'd0) begin errors++; $display("FAIL reset_last_pc got %0d want 0", last_pc); end
    endtask

    task automatic test_budget_run();
        int n_grant = 0;
        int n_done  = 0;
        ila_valid = 1'b1; ila_decode = 3'b001; ila_pc = 8'h10; budget = 4'd4; cmd_run = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (ila_grant !== exp_grant()) begin errors++; $display("FAIL budget_grant cyc %0d got %b want %b", c, ila_grant, exp_grant()); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL budget_done cyc %0d got %b want %b", c, done, m_done); end
            if (ila_grant == 3'b001) n_grant++;
            if (done) n_done++;
            tick();
            ila_pc = ila_pc + 8'd1;
        end
        checks++; if (n_grant != 4) begin errors++; $display("FAIL budget_count got %0d want 4", n_grant); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL budget_done_pulses got %0d want 1", n_done); end
        checks++; if (retired !== 4'd4) begin errors++; $display("FAIL budget_retired got %0d want 4", retired); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL budget_idle busy %b want 0", busy); end
    endtask

    task automatic test_step_wait();
        ila_decode = 3'b010; ila_valid = 1'b0; cmd_step = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ila_grant !== 3'b000) begin errors++; $display("FAIL step_wait_grant cyc %0d got %b want 000", c, ila_grant); end
            tick();
        end
        ila_valid = 1'b1; ila_pc = 8'h42;
        @(negedge clk);
        checks++; if (ila_grant !== 3'b010) begin errors++; $display("FAIL step_grant got %b want 010", ila_grant); end
        tick();
        ila_valid = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL step_done got %b want 1", done); end
        checks++; if (retired !== 4'd1) begin errors++; $display("FAIL step_retired got %0d want 1", retired); end
        checks++; if (last_pc !== 8'h42) begin errors++; $display("FAIL step_last_pc got %h want 42", last_pc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL step_busy got %b want 0", busy); end
    endtask

    task automatic test_integrity();
        budget = 4'd0; ila_valid = 1'b1; ila_decode = 3'b001; cmd_run = 1'b1;
        tick();
        ila_decode = 3'b110;
        @(negedge clk);
        checks++; if (ila_grant !== 3'b000) begin errors++; $display("FAIL integ_grant got %b want 000", ila_grant); end
        tick();
        ila_decode = 3'b001; cmd_run = 1'b1;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL integ_err got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL integ_halt_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL integ_done got %b want 0", done); end
        tick();
        @(negedge clk);
        checks++; if (ila_grant !== 3'b000) begin errors++; $display("FAIL integ_run_ignored grant %b want 000", ila_grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL integ_run_ignored busy %b want 0", busy); end
        cmd_stop = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL integ_clear err %b want 0", err); end
        checks++; if (m_mode != 0) begin errors++; $display("FAIL integ_model_mode got %0d want 0", m_mode); end
    endtask

    task automatic test_stop_step();
        budget = 4'd0; ila_valid = 1'b1; ila_decode = 3'b100; cmd_run = 1'b1;
        tick(); tick(); tick();
        cmd_stop = 1'b1; cmd_step = 1'b1;
        @(negedge clk);
        checks++; if (ila_grant !== 3'b000) begin errors++; $display("FAIL stop_grant got %b want 000", ila_grant); end
        tick();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done got %b want 0", done); end
        checks++; if (retired !== 4'd2) begin errors++; $display("FAIL stop_retired got %0d want 2", retired); end
    endtask

    task automatic test_saturation();
        budget = 4'd0; ila_valid = 1'b1; ila_decode = 3'b001; cmd_run = 1'b1;
        tick();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (ila_grant !== 3'b001) begin errors++; $display("FAIL sat_grant cyc %0d got %b want 001", c, ila_grant); end
            tick();
        end
        @(negedge clk);
        checks++; if (retired !== 4'd15) begin errors++; $display("FAIL sat_retired got %0d want 15", retired); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_busy got %b want 1", busy); end
        cmd_stop = 1'b1;
        tick();
    endtask

`ifdef ILA_GRANT_SEQ_BKPT_EN
    task automatic test_bkpt();
        logic [NI-1:0] g;
        bkpt_en = 1'b1; bkpt_pc = 8'h05; ila_pc = 8'h00;
        ila_valid = 1'b1; ila_decode = 3'b001; budget = 4'd0; cmd_run = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            g = ila_grant;
            checks++; if (g !== ((ila_pc < 8'h05) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL bkpt_grant pc %0d got %b", ila_pc, g); end
            tick();
            if (g != '0) ila_pc = ila_pc + 8'd1;
        end
        @(negedge clk);
        checks++; if (bkpt_hit !== 1'b1) begin errors++; $display("FAIL bkpt_hit got %b want 1", bkpt_hit); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL bkpt_done got %b want 0", done); end
        checks++; if (last_pc !== 8'h04) begin errors++; $display("FAIL bkpt_last_pc got %h want 04", last_pc); end
        cmd_step = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (ila_grant !== 3'b001) begin errors++; $display("FAIL bkpt_step_grant got %b want 001", ila_grant); end
        tick();
        @(negedge clk);
        checks++; if (last_pc !== 8'h05) begin errors++; $display("FAIL bkpt_step_pc got %h want 05", last_pc); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bkpt_step_done got %b want 1", done); end
        bkpt_en = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(299) == 0);
            cmd_stop   = ($urandom_range(19) == 0);
            cmd_step   = ($urandom_range(14) == 0);
            cmd_run    = ($urandom_range(9) == 0);
            ila_valid  = ($urandom_range(3) != 0);
            ila_decode = ($urandom_range(11) == 0) ? NI'($urandom_range(7)) : NI'(1 << $urandom_range(2));
            ila_pc     = PW'($urandom_range(7));
            budget     = CW'($urandom_range(15));
`ifdef ILA_GRANT_SEQ_BKPT_EN
            bkpt_en    = ($urandom_range(3) == 0);
            bkpt_pc    = 8'h03;
`endif
            @(negedge clk);
            checks++; if (ila_grant !== exp_grant()) begin errors++; $display("FAIL rnd_grant it %0d got %b want %b", i, ila_grant, exp_grant()); end
            checks++; if (busy !== (m_mode == 1 || m_mode == 2)) begin errors++; $display("FAIL rnd_busy it %0d got %b mode %0d", i, busy, m_mode); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done it %0d got %b want %b", i, done, m_done); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err it %0d got %b want %b", i, err, m_err); end
            checks++; if (retired !== CW'(m_retired)) begin errors++; $display("FAIL rnd_retired it %0d got %0d want %0d", i, retired, m_retired); end
            checks++; if (last_pc !== PW'(m_last_pc)) begin errors++; $display("FAIL rnd_last_pc it %0d got %0d want %0d", i, last_pc, m_last_pc); end
`ifdef ILA_GRANT_SEQ_BKPT_EN
            checks++; if (bkpt_hit !== m_bkpt) begin errors++; $display("FAIL rnd_bkpt it %0d got %b want %b", i, bkpt_hit, m_bkpt); end
`endif
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_budget_run();
        test_step_wait();
        test_integrity();
        test_stop_step();
        test_saturation();
`ifdef ILA_GRANT_SEQ_BKPT_EN
        test_bkpt();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
